// File: rtl/blur_row_sched_if.sv
// blur_row_sched_if: ori_img read handshake, window load, kernel engine and blur_img write signals.
interface blur_row_sched_if #(parameter int ROW_W = 9);
    logic             rd_req;
    logic [ROW_W-1:0] rd_addr;
    logic             rd_gnt;
    logic             win_load;
    logic [2:0]       win_idx;
    logic             eng_go;
    logic             eng_done;
    logic             wr_en;
    logic [ROW_W-1:0] wr_addr;
    logic [1:0]       lvl;
    modport master (
        output rd_req, rd_addr, win_load, win_idx, eng_go, wr_en, wr_addr, lvl,
        input  rd_gnt, eng_done
    );
    modport slave (
        input  rd_req, rd_addr, win_load, win_idx, eng_go, wr_en, wr_addr, lvl,
        output rd_gnt, eng_done
    );
endinterface

// File: rtl/blur_row_sched.sv
// blur_row_sched: walks the four blur levels row by row, fetching the clamped
// source window from ori_img, kicking the kernel engine and writing each result row.
module blur_row_sched #(
    parameter int ROWS  = 480,
    parameter int ROW_W = 9,
    parameter int R0    = 1,
    parameter int R1    = 2,
    parameter int R2    = 2,
    parameter int R3    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    blur_row_sched_if.master        bus,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, READ, GO, WAIT, WRITE, DONE} state_t;

    localparam logic signed [ROW_W+1:0] LIM = (ROW_W+2)'(ROWS - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [2:0]       t_q, t_d;
    logic [1:0]       lvl_q, lvl_d;
    logic             win_load_q, win_load_d;
    logic [2:0]       win_idx_q, win_idx_d;
    logic [2:0]       r;
    logic signed [ROW_W+1:0] src;
    logic             gnt;

    always_comb begin
        r   = lvl_q == 2'd0 ? 3'(R0) : lvl_q == 2'd1 ? 3'(R1) : lvl_q == 2'd2 ? 3'(R2) : 3'(R3);
        src = $signed((ROW_W+2)'(row_q)) - $signed((ROW_W+2)'(r)) + $signed((ROW_W+2)'(t_q));
        gnt = state_q == READ && bus.rd_gnt;
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        t_d        = t_q;
        lvl_d      = lvl_q;
        win_load_d = gnt;
        win_idx_d  = gnt ? t_q : 3'd0;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                row_d   = '0;
                t_d     = '0;
                lvl_d   = '0;
            end
            READ: if (gnt) begin
                state_d = t_q == 3'(r << 1) ? GO : READ;
                t_d     = t_q == 3'(r << 1) ? t_q : t_q + 3'd1;
            end
            GO:   state_d = WAIT;
            WAIT: state_d = bus.eng_done ? WRITE : WAIT;
            WRITE: begin
                t_d = '0;
                if (row_q < ROW_W'(ROWS - 1)) begin
                    state_d = READ;
                    row_d   = row_q + ROW_W'(1);
                end else if (lvl_q < 2'd3) begin
                    state_d = READ;
                    row_d   = '0;
                    lvl_d   = lvl_q + 2'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
                lvl_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            t_q        <= '0;
            lvl_q      <= '0;
            win_load_q <= 1'b0;
            win_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            t_q        <= t_d;
            lvl_q      <= lvl_d;
            win_load_q <= win_load_d;
            win_idx_q  <= win_idx_d;
        end
    end

    // Borders replicate the edge row: negative addresses pin to 0, overshoot to ROWS-1.
    assign bus.rd_addr  = src[ROW_W+1] ? '0 : src > LIM ? LIM[ROW_W-1:0] : src[ROW_W-1:0];
    assign bus.rd_req   = state_q == READ;
    assign bus.win_load = win_load_q;
    assign bus.win_idx  = win_idx_q;
    assign bus.eng_go   = state_q == GO;
    assign bus.wr_en    = state_q == WRITE;
    assign bus.wr_addr  = row_q;
    assign bus.lvl      = lvl_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
endmodule

// File: tb/tb_blur_row_sched.sv
// tb_blur_row_sched: scoreboard bench; expected reads/loads/writes of a whole pyramid
// are queued at start and consumed as the scheduler produces them.
module tb_blur_row_sched;
    localparam int ROWS  = 480;
    localparam int ROW_W = 9;

    typedef struct {
        logic [ROW_W-1:0] addr;
        logic [2:0]       idx;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic gnt = 1'b1;
    logic resp_done = 1'b0;
    logic extra_done = 1'b0;
    logic go_seen = 1'b0;
    logic busy, done;
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    rd_t  rdq[$];
    logic [ROW_W+1:0] wq[$];
    logic exp_load = 1'b0;
    logic [2:0] exp_idx = '0;
    logic stalled_prev = 1'b0;
    logic [ROW_W-1:0] prev_addr = '0;

    blur_row_sched_if #(.ROW_W(ROW_W)) bus ();

    assign bus.rd_gnt   = gnt;
    assign bus.eng_done = resp_done | extra_done;

    blur_row_sched #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int radius(input int l);
        return l == 0 ? 1 : l == 3 ? 3 : 2;
    endfunction

    task automatic push_model();
        rd_t e;
        for (int l = 0; l < 4; l++)
            for (int row = 0; row < ROWS; row++) begin
                for (int t = 0; t <= 2 * radius(l); t++) begin
                    int a;
                    a = row - radius(l) + t;
                    a = a < 0 ? 0 : a > ROWS - 1 ? ROWS - 1 : a;
                    e.addr = ROW_W'(a);
                    e.idx  = 3'(t);
                    rdq.push_back(e);
                end
                wq.push_back({2'(l), ROW_W'(row)});
            end
    endtask

    // Monitor and engine responder: eng_done rises the cycle after eng_go.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_load     = 1'b0;
            stalled_prev = 1'b0;
            go_seen      = 1'b0;
            resp_done    = 1'b0;
        end else begin
            resp_done = go_seen;
            go_seen   = bus.eng_go;
            chk("win_load", bus.win_load, exp_load);
            if (exp_load) chk("win_idx", bus.win_idx, exp_idx);
            if (bus.eng_go) chk("go_with_load", bus.win_load, 1);
            if (stalled_prev && bus.rd_req) chk("rd_addr_hold", bus.rd_addr, prev_addr);
            exp_load = bus.rd_req && bus.rd_gnt;
            if (exp_load) begin
                chk("rd_q_nonempty", rdq.size() != 0, 1);
                if (rdq.size() != 0) begin
                    rd_t e;
                    e = rdq.pop_front();
                    chk("rd_addr", bus.rd_addr, e.addr);
                    exp_idx = e.idx;
                end
            end
            stalled_prev = bus.rd_req && !bus.rd_gnt;
            prev_addr    = bus.rd_addr;
            if (bus.wr_en) begin
                writes++;
                chk("wr_q_nonempty", wq.size() != 0, 1);
                if (wq.size() != 0) chk("wr_lvl_row", {bus.lvl, bus.wr_addr}, wq.pop_front());
            end
        end
    end

    initial begin
        int n;
        bit hit;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rd_req", bus.rd_req, 0);
        // Run 1: grant stall at tap 1 of the first row, then random grants up to lvl 2 row 5.
        push_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run1_busy", busy, 1);
        @(posedge clk); #1;
        gnt = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_rd_req", bus.rd_req, 1);
            chk("stall_rd_addr", bus.rd_addr, 0);
            chk("stall_no_load", bus.win_load, 0);
        end
        gnt = 1'b1;
        n = 0;
        hit = 0;
        while (!hit && n < 40000) begin
            @(posedge clk); #1;
            n++;
            hit = bus.lvl == 2'd2 && bus.wr_addr == ROW_W'(5) && bus.rd_req;
            gnt = $urandom_range(0, 3) != 0;
        end
        chk("reach_lvl2_row5", hit, 1);
        // Asynchronous reset in the middle of a row read.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rd_req", bus.rd_req, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_win_load", bus.win_load, 0);
        chk("rst_win_idx", bus.win_idx, 0);
        chk("rst_eng_go", bus.eng_go, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_lvl", bus.lvl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rdq.delete();
        wq.delete();
        gnt = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_wr_en", bus.wr_en, 0);
            chk("post_rst_busy", busy, 0);
        end
        // Run 2: clean full pyramid with ignored start and eng_done pulses.
        writes = 0;
        push_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run2_first_lvl", bus.lvl, 0);
        chk("run2_first_row", bus.wr_addr, 0);
        n = 0;
        while (!done && n < ROWS * 32 + 100) begin
            @(posedge clk); #1;
            n++;
            extra_done = n == 1;
            start      = n == 10;
        end
        chk("done_cycle", n, ROWS * 32);
        chk("done_high", done, 1);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_drop", busy, 0);
        chk("write_count", writes, ROWS * 4);
        chk("rd_q_drained", rdq.size(), 0);
        chk("wr_q_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
